// File: rtl/mips_mc_control_if.sv
// Control-side bundle of the multicycle MIPS datapath.
// The master drives the datapath controls. The slave supplies the IR fields, the ALU zero flag and the memory handshake.
interface mips_mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       pc_en;
  logic [1:0] pc_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zext;
  logic [2:0] alu_op;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal;
  logic [3:0] dbg_state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_en, pc_src,
           alu_src_a, alu_src_b, imm_zext, alu_op, reg_dst,
           mem_to_reg, reg_write, illegal, dbg_state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_read, mem_write, iord, ir_write, pc_en, pc_src,
           alu_src_a, alu_src_b, imm_zext, alu_op, reg_dst,
           mem_to_reg, reg_write, illegal, dbg_state
  );
endinterface

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM.
// Sequences the fetch, decode, execute, memory and writeback steps, and decodes the datapath controls from the state and the IR fields.
module mips_mc_control #(
  parameter logic [3:0] RESET_STATE_ENC = 4'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  mips_mc_control_if.master  ctl_io
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_R_EXEC    = 4'd2,
    S_R_WB      = 4'd3,
    S_I_EXEC    = 4'd4,
    S_I_WB      = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e state_q;
  state_e state_d;
  logic   funct_ok;

  // R-type function codes the datapath supports
  always_comb begin
    funct_ok = 1'b0;
    case (ctl_io.funct)
      FN_SLL, FN_SRL, FN_ADD, FN_ADDU, FN_SUB,
      FN_SUBU, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
      default:                        funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= state_e'(RESET_STATE_ENC);
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and controls. Everything stays idle while reset is held low, so requests drop at once.
  always_comb begin
    state_d           = state_q;
    ctl_io.mem_read   = 1'b0;
    ctl_io.mem_write  = 1'b0;
    ctl_io.iord       = 1'b0;
    ctl_io.ir_write   = 1'b0;
    ctl_io.pc_en      = 1'b0;
    ctl_io.pc_src     = 2'b00;
    ctl_io.alu_src_a  = 2'b00;
    ctl_io.alu_src_b  = 2'b00;
    ctl_io.imm_zext   = 1'b0;
    ctl_io.alu_op     = ALU_ADD;
    ctl_io.reg_dst    = 1'b0;
    ctl_io.mem_to_reg = 1'b0;
    ctl_io.reg_write  = 1'b0;
    ctl_io.illegal    = 1'b0;

    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          ctl_io.mem_read  = 1'b1;
          ctl_io.alu_src_b = 2'b01;
          if (ctl_io.mem_ready) begin
            ctl_io.ir_write = 1'b1;
            ctl_io.pc_en    = 1'b1;
            state_d         = S_DECODE;
          end
        end

        S_DECODE: begin
          ctl_io.alu_src_b = 2'b11;
          case (ctl_io.opcode)
            OP_RTYPE:                  state_d = funct_ok ? S_R_EXEC : S_TRAP;
            OP_LW, OP_SW:              state_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE:            state_d = S_BRANCH;
            OP_J:                      state_d = S_JUMP;
            OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_ANDI, OP_ORI:           state_d = S_I_EXEC;
            default:                   state_d = S_TRAP;
          endcase
        end

        S_R_EXEC: begin
          ctl_io.alu_src_a = 2'b01;
          case (ctl_io.funct)
            FN_SLL: begin
              ctl_io.alu_src_a = 2'b10;
              ctl_io.alu_op    = ALU_SLL;
            end
            FN_SRL: begin
              ctl_io.alu_src_a = 2'b10;
              ctl_io.alu_op    = ALU_SRL;
            end
            FN_SUB, FN_SUBU: ctl_io.alu_op = ALU_SUB;
            FN_AND:          ctl_io.alu_op = ALU_AND;
            FN_OR:           ctl_io.alu_op = ALU_OR;
            FN_SLT:          ctl_io.alu_op = ALU_SLT;
            default:         ctl_io.alu_op = ALU_ADD;
          endcase
          state_d = S_R_WB;
        end

        S_R_WB: begin
          ctl_io.reg_dst   = 1'b1;
          ctl_io.reg_write = 1'b1;
          state_d          = S_FETCH;
        end

        S_I_EXEC: begin
          ctl_io.alu_src_a = 2'b01;
          ctl_io.alu_src_b = 2'b10;
          case (ctl_io.opcode)
            OP_SLTI: ctl_io.alu_op = ALU_SLT;
            OP_ANDI: begin
              ctl_io.imm_zext = 1'b1;
              ctl_io.alu_op   = ALU_AND;
            end
            OP_ORI: begin
              ctl_io.imm_zext = 1'b1;
              ctl_io.alu_op   = ALU_OR;
            end
            default: ctl_io.alu_op = ALU_ADD;
          endcase
          state_d = S_I_WB;
        end

        S_I_WB: begin
          ctl_io.reg_write = 1'b1;
          state_d          = S_FETCH;
        end

        S_MEM_ADDR: begin
          ctl_io.alu_src_a = 2'b01;
          ctl_io.alu_src_b = 2'b10;
          state_d = (ctl_io.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        end

        S_MEM_READ: begin
          ctl_io.mem_read = 1'b1;
          ctl_io.iord     = 1'b1;
          if (ctl_io.mem_ready) state_d = S_MEM_WB;
        end

        S_MEM_WB: begin
          ctl_io.mem_to_reg = 1'b1;
          ctl_io.reg_write  = 1'b1;
          state_d           = S_FETCH;
        end

        S_MEM_WRITE: begin
          ctl_io.mem_write = 1'b1;
          ctl_io.iord      = 1'b1;
          if (ctl_io.mem_ready) state_d = S_FETCH;
        end

        S_BRANCH: begin
          ctl_io.alu_src_a = 2'b01;
          ctl_io.alu_op    = ALU_SUB;
          ctl_io.pc_src    = 2'b01;
          ctl_io.pc_en     = (ctl_io.opcode == OP_BNE) ? !ctl_io.zero : ctl_io.zero;
          state_d          = S_FETCH;
        end

        S_JUMP: begin
          ctl_io.pc_src = 2'b10;
          ctl_io.pc_en  = 1'b1;
          state_d       = S_FETCH;
        end

        S_TRAP: begin
          ctl_io.illegal = 1'b1;
        end

        default: state_d = S_TRAP;
      endcase
    end
  end

  assign ctl_io.dbg_state = 4'(state_q);

endmodule

// File: tb/tb_mips_mc_control.sv
// Cycle-by-cycle vector table for the multicycle control FSM.
// Expected outputs are queued as each vector is driven and popped when the outputs are sampled.
module tb_mips_mc_control;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
    logic       mw;
    logic       io;
    logic       irw;
    logic       pce;
    logic [1:0] pcs;
    logic [1:0] asa;
    logic [1:0] asb;
    logic       zx;
    logic [2:0] aop;
    logic       rd;
    logic       m2r;
    logic       rw;
    logic       ill;
  } outs_t;

  typedef struct {
    string      name;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  vec_t  vecs[$];
  outs_t sb[$];

  mips_mc_control_if bus ();

  mips_mc_control #(.RESET_STATE_ENC(4'd0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ctl_io (bus.master)
  );

  always #5 clk = ~clk;

  function automatic outs_t mk(input logic [3:0] st, input logic mr, input logic mw,
                               input logic io, input logic irw, input logic pce,
                               input logic [1:0] pcs, input logic [1:0] asa,
                               input logic [1:0] asb, input logic zx,
                               input logic [2:0] aop, input logic rd,
                               input logic m2r, input logic rw, input logic ill);
    outs_t o;
    o = '{st: st, mr: mr, mw: mw, io: io, irw: irw, pce: pce, pcs: pcs, asa: asa,
          asb: asb, zx: zx, aop: aop, rd: rd, m2r: m2r, rw: rw, ill: ill};
    return o;
  endfunction

  task automatic add(input string name, input logic r, input logic [5:0] op,
                     input logic [5:0] fn, input logic z, input logic rdy, input outs_t e);
    vec_t v;
    v.name = name; v.rst_n = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  function automatic outs_t sample();
    outs_t o;
    o = '{st: bus.dbg_state, mr: bus.mem_read, mw: bus.mem_write, io: bus.iord,
          irw: bus.ir_write, pce: bus.pc_en, pcs: bus.pc_src, asa: bus.alu_src_a,
          asb: bus.alu_src_b, zx: bus.imm_zext, aop: bus.alu_op, rd: bus.reg_dst,
          m2r: bus.mem_to_reg, rw: bus.reg_write, ill: bus.illegal};
    return o;
  endfunction

  initial begin
    outs_t idle, f_go, f_wait, dec;
    outs_t exp, act;
    bit    seen;
    bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    //        st     mr mw io irw pce pcs    asa    asb    zx aop     rd m2r rw ill
    idle   = mk(4'd0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 0, 0, 0, 0);
    f_go   = mk(4'd0, 1, 0, 0, 1, 1, 2'b00, 2'b00, 2'b01, 0, 3'b010, 0, 0, 0, 0);
    f_wait = mk(4'd0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0, 3'b010, 0, 0, 0, 0);
    dec    = mk(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0, 3'b010, 0, 0, 0, 0);

    add("reset", 0, 6'h00, 6'h20, 0, 1, idle);
    // add $3,$1,$2
    add("add_fetch", 1, 6'h00, 6'h20, 0, 1, f_go);
    add("add_decode", 1, 6'h00, 6'h20, 0, 1, dec);
    add("add_exec", 1, 6'h00, 6'h20, 0, 1, mk(4'd2, 0,0,0,0,0, 2'b00, 2'b01, 2'b00, 0, 3'b010, 0,0,0,0));
    add("add_wb", 1, 6'h00, 6'h20, 0, 1, mk(4'd3, 0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 1,0,1,0));
    // lw with two wait cycles
    add("lw_fetch", 1, 6'h23, 6'h00, 0, 1, f_go);
    add("lw_decode", 1, 6'h23, 6'h00, 0, 1, dec);
    add("lw_addr", 1, 6'h23, 6'h00, 0, 1, mk(4'd6, 0,0,0,0,0, 2'b00, 2'b01, 2'b10, 0, 3'b010, 0,0,0,0));
    add("lw_wait1", 1, 6'h23, 6'h00, 0, 0, mk(4'd7, 1,0,1,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 0,0,0,0));
    add("lw_wait2", 1, 6'h23, 6'h00, 0, 0, mk(4'd7, 1,0,1,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 0,0,0,0));
    add("lw_ready", 1, 6'h23, 6'h00, 0, 1, mk(4'd7, 1,0,1,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 0,0,0,0));
    add("lw_wb", 1, 6'h23, 6'h00, 0, 1, mk(4'd8, 0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 0,1,1,0));
    // beq taken / not taken, bne taken
    add("beq1_fetch", 1, 6'h04, 6'h00, 0, 1, f_go);
    add("beq1_decode", 1, 6'h04, 6'h00, 1, 1, dec);
    add("beq1_branch", 1, 6'h04, 6'h00, 1, 1, mk(4'd10, 0,0,0,0,1, 2'b01, 2'b01, 2'b00, 0, 3'b110, 0,0,0,0));
    add("beq0_fetch", 1, 6'h04, 6'h00, 0, 1, f_go);
    add("beq0_decode", 1, 6'h04, 6'h00, 0, 1, dec);
    add("beq0_branch", 1, 6'h04, 6'h00, 0, 1, mk(4'd10, 0,0,0,0,0, 2'b01, 2'b01, 2'b00, 0, 3'b110, 0,0,0,0));
    add("bne_fetch", 1, 6'h05, 6'h00, 0, 1, f_go);
    add("bne_decode", 1, 6'h05, 6'h00, 0, 1, dec);
    add("bne_branch", 1, 6'h05, 6'h00, 0, 1, mk(4'd10, 0,0,0,0,1, 2'b01, 2'b01, 2'b00, 0, 3'b110, 0,0,0,0));
    // shifts, sub, andi, jump
    add("sll_fetch", 1, 6'h00, 6'h00, 0, 1, f_go);
    add("sll_decode", 1, 6'h00, 6'h00, 0, 1, dec);
    add("sll_exec", 1, 6'h00, 6'h00, 0, 1, mk(4'd2, 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 0, 3'b100, 0,0,0,0));
    add("sll_wb", 1, 6'h00, 6'h00, 0, 1, mk(4'd3, 0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 1,0,1,0));
    add("srl_fetch", 1, 6'h00, 6'h02, 0, 1, f_go);
    add("srl_decode", 1, 6'h00, 6'h02, 0, 1, dec);
    add("srl_exec", 1, 6'h00, 6'h02, 0, 1, mk(4'd2, 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 0, 3'b101, 0,0,0,0));
    add("srl_wb", 1, 6'h00, 6'h02, 0, 1, mk(4'd3, 0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 1,0,1,0));
    add("slt_fetch", 1, 6'h00, 6'h2A, 0, 1, f_go);
    add("slt_decode", 1, 6'h00, 6'h2A, 0, 1, dec);
    add("slt_exec", 1, 6'h00, 6'h2A, 0, 1, mk(4'd2, 0,0,0,0,0, 2'b00, 2'b01, 2'b00, 0, 3'b111, 0,0,0,0));
    add("slt_wb", 1, 6'h00, 6'h2A, 0, 1, mk(4'd3, 0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 1,0,1,0));
    add("andi_fetch", 1, 6'h0C, 6'h00, 0, 1, f_go);
    add("andi_decode", 1, 6'h0C, 6'h00, 0, 1, dec);
    add("andi_exec", 1, 6'h0C, 6'h00, 0, 1, mk(4'd4, 0,0,0,0,0, 2'b00, 2'b01, 2'b10, 1, 3'b000, 0,0,0,0));
    add("andi_wb", 1, 6'h0C, 6'h00, 0, 1, mk(4'd5, 0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 0,0,1,0));
    add("addi_fetch", 1, 6'h08, 6'h00, 0, 1, f_go);
    add("addi_decode", 1, 6'h08, 6'h00, 0, 1, dec);
    add("addi_exec", 1, 6'h08, 6'h00, 0, 1, mk(4'd4, 0,0,0,0,0, 2'b00, 2'b01, 2'b10, 0, 3'b010, 0,0,0,0));
    add("addi_wb", 1, 6'h08, 6'h00, 0, 1, mk(4'd5, 0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 0,0,1,0));
    add("j_fetch", 1, 6'h02, 6'h00, 0, 1, f_go);
    add("j_decode", 1, 6'h02, 6'h00, 0, 1, dec);
    add("j_jump", 1, 6'h02, 6'h00, 0, 1, mk(4'd11, 0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0, 3'b010, 0,0,0,0));
    // sw: fetch wait, then reset while the write is outstanding
    add("sw_fetch_wait", 1, 6'h2B, 6'h00, 0, 0, f_wait);
    add("sw_fetch", 1, 6'h2B, 6'h00, 0, 1, f_go);
    add("sw_decode", 1, 6'h2B, 6'h00, 0, 1, dec);
    add("sw_addr", 1, 6'h2B, 6'h00, 0, 1, mk(4'd6, 0,0,0,0,0, 2'b00, 2'b01, 2'b10, 0, 3'b010, 0,0,0,0));
    add("sw_wait", 1, 6'h2B, 6'h00, 0, 0, mk(4'd9, 0,1,1,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 0,0,0,0));
    add("sw_wait2", 1, 6'h2B, 6'h00, 0, 0, mk(4'd9, 0,1,1,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 0,0,0,0));
    add("sw_reset", 0, 6'h2B, 6'h00, 0, 0, idle);
    add("sw_restart", 1, 6'h2B, 6'h00, 0, 1, f_go);
    add("sw_decode2", 1, 6'h2B, 6'h00, 0, 1, dec);
    add("sw_addr2", 1, 6'h2B, 6'h00, 0, 1, mk(4'd6, 0,0,0,0,0, 2'b00, 2'b01, 2'b10, 0, 3'b010, 0,0,0,0));
    add("sw_done", 1, 6'h2B, 6'h00, 0, 1, mk(4'd9, 0,1,1,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 0,0,0,0));
    // illegal opcode traps until reset
    add("ill_fetch", 1, 6'h3F, 6'h00, 0, 1, f_go);
    add("ill_decode", 1, 6'h3F, 6'h00, 0, 1, dec);
    add("ill_trap", 1, 6'h3F, 6'h00, 1, 1, mk(4'd12, 0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 0,0,0,1));
    add("ill_sticky", 1, 6'h00, 6'h20, 1, 1, mk(4'd12, 0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 0,0,0,1));
    add("ill_reset", 0, 6'h00, 6'h20, 0, 1, idle);
    add("ill_refetch", 1, 6'h00, 6'h08, 0, 1, f_go);
    // illegal funct
    add("jr_decode", 1, 6'h00, 6'h08, 0, 1, dec);
    add("jr_trap", 1, 6'h00, 6'h08, 0, 1, mk(4'd12, 0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 0,0,0,1));
    add("jr_reset", 0, 6'h00, 6'h08, 0, 1, idle);
    add("jr_refetch_wait", 1, 6'h00, 6'h20, 0, 0, f_wait);

    // reset state
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.dbg_state !== 4'd0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 ||
        bus.ir_write !== 1'b0 || bus.pc_en !== 1'b0 || bus.reg_write !== 1'b0 ||
        bus.alu_op !== 3'b010 || bus.illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: dbg_state=%0d mem_read=%b mem_write=%b alu_op=%b illegal=%b",
               bus.dbg_state, bus.mem_read, bus.mem_write, bus.alu_op, bus.illegal);
    end

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n         = vecs[i].rst_n;
      bus.opcode    = vecs[i].op;
      bus.funct     = vecs[i].fn;
      bus.zero      = vecs[i].z;
      bus.mem_ready = vecs[i].rdy;
      sb.push_back(vecs[i].exp);
      #1;
      exp = sb.pop_front();
      act = sample();
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: got %h, want %h (st=%0d/%0d mr=%b/%b mw=%b/%b pc_en=%b/%b alu_op=%b/%b)",
                 vecs[i].name, act, exp, act.st, exp.st, act.mr, exp.mr, act.mw, exp.mw,
                 act.pce, exp.pce, act.aop, exp.aop);
      end
    end

    // fetch holds its request while memory stalls
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.opcode    = 6'h00;
      bus.funct     = 6'h20;
      bus.mem_ready = 1'b0;
      #1;
      n_checks++;
      if (bus.dbg_state !== 4'd0 || bus.mem_read !== 1'b1 || bus.iord !== 1'b0 ||
          bus.ir_write !== 1'b0 || bus.pc_en !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_stall%0d: dbg_state=%0d mem_read=%b iord=%b ir_write=%b pc_en=%b",
                 k, bus.dbg_state, bus.mem_read, bus.iord, bus.ir_write, bus.pc_en);
      end
    end

    // fetch must complete within a bounded wait once memory is ready
    @(negedge clk);
    bus.mem_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (bus.dbg_state === 4'd1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL fetch_timeout: DECODE not reached, dbg_state=%0d", bus.dbg_state);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
